// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared raster geometry, coordinate type and axis direction
//
// Purpose : common definitions for the sprite motion/addressing stage.
// Contents: H_ACTIVE/V_ACTIVE visible raster size, coord_t 10-bit raster
//           coordinate, dir_t per-axis travel direction (FWD = right/down).
package video_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;

   typedef logic [9:0] coord_t;

   // Forward is towards larger coordinates: right for x, down for y.
   // The x and y direction bits together give the four motion states
   // RD, RU, LD, LU.
   typedef enum logic {
      FWD = 1'b0,
      BWD = 1'b1
   } dir_t;

endpackage

// File: rtl/bounce_axis.sv
// rtl/bounce_axis.sv - one axis of sprite motion with edge reflection
//
// Purpose : steps a position by STEP on each tick, clamping to 0..LIMIT and
//           reversing direction when the step would leave that range.
// Ports   : clk, reset     - clock, synchronous active-high reset
//           tick           - advance one step this cycle
//           pos  [9:0]     - current position (registered)
//           dir            - current direction, 0 = forward (registered)
//           reflect        - one-cycle pulse the cycle after a reflecting tick
module bounce_axis
   import video_pkg::*;
#(
   parameter int LIMIT = 619,
   parameter int STEP  = 1,
   parameter int P0    = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   output logic [9:0] pos,
   output logic       dir,
   output logic       reflect
);

   dir_t        dir_q, dir_d;
   coord_t      pos_q, pos_d;
   logic        reflect_d;
   logic [10:0] fwd_sum;

   // One extra bit so pos + STEP cannot wrap before the limit compare.
   assign fwd_sum = {1'b0, pos_q} + 11'(STEP);

   always_ff @(posedge clk) begin
      if (reset) begin
         pos_q   <= coord_t'(P0);
         dir_q   <= FWD;
         reflect <= 1'b0;
      end else begin
         pos_q   <= pos_d;
         dir_q   <= dir_d;
         reflect <= reflect_d;
      end
   end

   always_comb begin
      pos_d     = pos_q;
      dir_d     = dir_q;
      reflect_d = 1'b0;
      if (tick) begin
         case (dir_q)
            FWD: begin
               if (fwd_sum > 11'(LIMIT)) begin
                  pos_d     = coord_t'(LIMIT);
                  dir_d     = BWD;
                  reflect_d = 1'b1;
               end else begin
                  pos_d = fwd_sum[9:0];
               end
            end
            BWD: begin
               if (pos_q < coord_t'(STEP)) begin
                  pos_d     = '0;
                  dir_d     = FWD;
                  reflect_d = 1'b1;
               end else begin
                  pos_d = pos_q - coord_t'(STEP);
               end
            end
            default: begin
               pos_d = pos_q;
               dir_d = FWD;
            end
         endcase
      end
   end

   assign pos = pos_q;
   assign dir = dir_q;

endmodule

// File: rtl/sprite_bouncer.sv
// rtl/sprite_bouncer.sv - bouncing sprite position, ROM addressing and video gating
//
// Purpose : moves a sprite once per frame_tick, bouncing off the frame edges,
//           turns the raster coordinate into image-relative ROM addresses and
//           re-aligns the ROM's registered pixel with the in-sprite/active
//           qualifiers (3 clocks from px_x/px_y/active to video_out).
// Ports   : clk, reset           - clock, synchronous active-high reset
//           enable               - motion enable (addressing always runs)
//           frame_tick           - one pulse per frame, during blanking
//           px_x, px_y [9:0]     - current raster coordinate
//           active               - raster inside the visible area
//           x_img, y_img [7:0]   - registered ROM address, 0 outside sprite
//           img_pixel            - ROM data, one cycle after the address
//           video_out            - final monochrome pixel (registered)
//           bounce, corner       - reflection pulses, the cycle after the tick
module sprite_bouncer
   import video_pkg::*;
#(
   parameter int IMG_W = 21,
   parameter int IMG_H = 230,
   parameter int STEP  = 1,
   parameter int X0    = 0,
   parameter int Y0    = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       frame_tick,
   input  logic [9:0] px_x,
   input  logic [9:0] px_y,
   input  logic       active,
   output logic [7:0] x_img,
   output logic [7:0] y_img,
   input  logic       img_pixel,
   output logic       video_out,
   output logic       bounce,
   output logic       corner
);

   localparam int LIMIT_X = H_ACTIVE - IMG_W;
   localparam int LIMIT_Y = V_ACTIVE - IMG_H;

   logic        step_tick;
   coord_t      pos_x, pos_y;
   logic        dir_x, dir_y;
   logic        reflect_x, reflect_y;
   logic [10:0] x_end, y_end;
   logic        in_spr;
   logic        in_spr_d1, in_spr_d2;
   logic        active_d1, active_d2;

   assign step_tick = frame_tick & enable;

   bounce_axis #(
      .LIMIT (LIMIT_X),
      .STEP  (STEP),
      .P0    (X0)
   ) u_axis_x (
      .clk     (clk),
      .reset   (reset),
      .tick    (step_tick),
      .pos     (pos_x),
      .dir     (dir_x),
      .reflect (reflect_x)
   );

   bounce_axis #(
      .LIMIT (LIMIT_Y),
      .STEP  (STEP),
      .P0    (Y0)
   ) u_axis_y (
      .clk     (clk),
      .reset   (reset),
      .tick    (step_tick),
      .pos     (pos_y),
      .dir     (dir_y),
      .reflect (reflect_y)
   );

   // Sprite extent is computed one bit wider so pos + IMG size never wraps.
   assign x_end = {1'b0, pos_x} + 11'(IMG_W);
   assign y_end = {1'b0, pos_y} + 11'(IMG_H);

   always_comb begin
      in_spr = (px_x >= pos_x) && ({1'b0, px_x} < x_end) &&
               (px_y >= pos_y) && ({1'b0, px_y} < y_end);
   end

   // Stage 1 drives the ROM address; stage 2 lines the qualifiers up with
   // the ROM's own output register; stage 3 is the gated video bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         x_img     <= '0;
         y_img     <= '0;
         in_spr_d1 <= 1'b0;
         active_d1 <= 1'b0;
         in_spr_d2 <= 1'b0;
         active_d2 <= 1'b0;
         video_out <= 1'b0;
      end else begin
         x_img     <= in_spr ? 8'(px_x - pos_x) : 8'd0;
         y_img     <= in_spr ? 8'(px_y - pos_y) : 8'd0;
         in_spr_d1 <= in_spr;
         active_d1 <= active;
         in_spr_d2 <= in_spr_d1;
         active_d2 <= active_d1;
         video_out <= img_pixel & in_spr_d2 & active_d2;
      end
   end

   assign bounce = reflect_x | reflect_y;
   assign corner = reflect_x & reflect_y;

   // A reflection leaves the axis pinned at the edge it hit and heading away:
   // backward at LIMIT after a forward hit, forward at 0 after a backward hit.
   assert property (@(posedge clk) disable iff (reset)
      reflect_x |-> ((dir_x == BWD) == (pos_x == coord_t'(LIMIT_X))));
   assert property (@(posedge clk) disable iff (reset)
      reflect_y |-> ((dir_y == BWD) == (pos_y == coord_t'(LIMIT_Y))));

endmodule

// File: tb/tb_sprite_bouncer.sv
// tb/tb_sprite_bouncer.sv - directed self-checking bench for sprite_bouncer
module tb_sprite_bouncer;

   logic       clk = 1'b0;
   logic       reset, enable, active, img_pixel;
   logic       tick_a, tick_b, tick_c;
   logic [9:0] px_x, px_y;

   logic [7:0] xa, ya, xb, yb, xc, yc;
   logic       va, vb, vc, ba, bb, bc, ca, cb, cc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // dut_a starts at (0,0), dut_b at (100,50), dut_c next to the corner.
   sprite_bouncer dut_a (
      .clk(clk), .reset(reset), .enable(enable), .frame_tick(tick_a),
      .px_x(px_x), .px_y(px_y), .active(active), .x_img(xa), .y_img(ya),
      .img_pixel(img_pixel), .video_out(va), .bounce(ba), .corner(ca)
   );

   sprite_bouncer #(.X0(100), .Y0(50)) dut_b (
      .clk(clk), .reset(reset), .enable(enable), .frame_tick(tick_b),
      .px_x(px_x), .px_y(px_y), .active(active), .x_img(xb), .y_img(yb),
      .img_pixel(img_pixel), .video_out(vb), .bounce(bb), .corner(cb)
   );

   sprite_bouncer #(.X0(618), .Y0(249)) dut_c (
      .clk(clk), .reset(reset), .enable(enable), .frame_tick(tick_c),
      .px_x(px_x), .px_y(px_y), .active(active), .x_img(xc), .y_img(yc),
      .img_pixel(img_pixel), .video_out(vc), .bounce(bc), .corner(cc)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_px(input int x, input int y, input logic act);
      px_x   = 10'(x);
      px_y   = 10'(y);
      active = act;
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; img_pixel = 1'b1;
      tick_a = 1'b0; tick_b = 1'b0; tick_c = 1'b0;
      drive_px(0, 0, 1'b0);
      cyc(2);

      // Reset state
      check("rst_pos_x_a", 32'(dut_a.u_axis_x.pos), 0);
      check("rst_pos_y_a", 32'(dut_a.u_axis_y.pos), 0);
      check("rst_dir_x_a", 32'(dut_a.u_axis_x.dir), 0);
      check("rst_dir_y_a", 32'(dut_a.u_axis_y.dir), 0);
      check("rst_x_img_a", 32'(xa), 0);
      check("rst_y_img_a", 32'(ya), 0);
      check("rst_video_a", 32'(va), 0);
      check("rst_bounce_a", 32'(ba), 0);
      check("rst_corner_a", 32'(ca), 0);
      check("rst_pos_x_b", 32'(dut_b.u_axis_x.pos), 100);
      check("rst_pos_y_b", 32'(dut_b.u_axis_y.pos), 50);
      check("rst_pos_x_c", 32'(dut_c.u_axis_x.pos), 618);
      reset = 1'b0;

      // Addressing and 3-clock pixel latency on dut_b at (100,50)
      drive_px(105, 60, 1'b1);
      cyc(1);
      check("addr_x_img", 32'(xb), 5);
      check("addr_y_img", 32'(yb), 10);
      drive_px(0, 0, 1'b1);
      cyc(1);
      check("video_lat2", 32'(vb), 0);
      cyc(1);
      check("video_lat3", 32'(vb), 1);
      cyc(1);
      check("video_lat4", 32'(vb), 0);

      // Just past the right side of the sprite
      drive_px(121, 60, 1'b1);
      cyc(1);
      check("out_x_img", 32'(xb), 0);
      check("out_y_img", 32'(yb), 0);
      cyc(2);
      check("out_video", 32'(vb), 0);

      // Last pixel inside, then just left of the sprite
      drive_px(120, 279, 1'b1);
      cyc(1);
      check("edge_x_img", 32'(xb), 20);
      check("edge_y_img", 32'(yb), 229);
      drive_px(99, 60, 1'b1);
      cyc(1);
      check("left_x_img", 32'(xb), 0);

      // Inside the sprite but outside the visible area
      drive_px(105, 60, 1'b0);
      cyc(3);
      check("inactive_video", 32'(vb), 0);
      drive_px(0, 0, 1'b0);

      // Right/bottom corner approach on dut_c (618,249), back-to-back ticks
      tick_c = 1'b1;
      cyc(1);
      check("c1_pos_x", 32'(dut_c.u_axis_x.pos), 619);
      check("c1_pos_y", 32'(dut_c.u_axis_y.pos), 250);
      check("c1_bounce", 32'(bc), 0);
      cyc(1);
      check("c2_pos_x", 32'(dut_c.u_axis_x.pos), 619);
      check("c2_pos_y", 32'(dut_c.u_axis_y.pos), 250);
      check("c2_bounce", 32'(bc), 1);
      check("c2_corner", 32'(cc), 1);
      check("c2_dir_x", 32'(dut_c.u_axis_x.dir), 1);
      check("c2_dir_y", 32'(dut_c.u_axis_y.dir), 1);
      tick_c = 1'b0;
      cyc(1);
      check("c3_bounce", 32'(bc), 0);
      check("c3_corner", 32'(cc), 0);
      tick_c = 1'b1;
      cyc(1);
      tick_c = 1'b0;
      check("c4_pos_x", 32'(dut_c.u_axis_x.pos), 618);
      check("c4_pos_y", 32'(dut_c.u_axis_y.pos), 249);
      check("c4_bounce", 32'(bc), 0);

      // Bottom-only bounce on dut_b: 200 ticks to (300,250), then reflect y
      tick_b = 1'b1;
      cyc(200);
      check("b200_pos_x", 32'(dut_b.u_axis_x.pos), 300);
      check("b200_pos_y", 32'(dut_b.u_axis_y.pos), 250);
      check("b200_bounce", 32'(bb), 0);
      cyc(1);
      tick_b = 1'b0;
      check("b201_pos_x", 32'(dut_b.u_axis_x.pos), 301);
      check("b201_pos_y", 32'(dut_b.u_axis_y.pos), 250);
      check("b201_bounce", 32'(bb), 1);
      check("b201_corner", 32'(cb), 0);
      check("b201_dir_y", 32'(dut_b.u_axis_y.dir), 1);
      check("b201_dir_x", 32'(dut_b.u_axis_x.dir), 0);

      // Enable gating on dut_a
      tick_a = 1'b1;
      cyc(3);
      tick_a = 1'b0;
      check("en_pos_x", 32'(dut_a.u_axis_x.pos), 3);
      check("en_pos_y", 32'(dut_a.u_axis_y.pos), 3);
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick_a = 1'b1;
         cyc(1);
         tick_a = 1'b0;
         cyc(1);
      end
      check("dis_pos_x", 32'(dut_a.u_axis_x.pos), 3);
      check("dis_pos_y", 32'(dut_a.u_axis_y.pos), 3);
      enable = 1'b1;

      // Mid-frame reset coinciding with a tick; dut_b shows a lit pixel first
      drive_px(305, 255, 1'b1);
      cyc(3);
      check("pre_rst_video_b", 32'(vb), 1);
      reset  = 1'b1;
      tick_a = 1'b1;
      cyc(1);
      check("rst_tick_pos_x_a", 32'(dut_a.u_axis_x.pos), 0);
      check("rst_tick_pos_y_a", 32'(dut_a.u_axis_y.pos), 0);
      check("rst_tick_bounce_a", 32'(ba), 0);
      check("rst_video_b_blank", 32'(vb), 0);
      check("rst_pos_x_b2", 32'(dut_b.u_axis_x.pos), 100);
      check("rst_dir_y_b2", 32'(dut_b.u_axis_y.dir), 0);
      reset  = 1'b0;
      tick_a = 1'b0;
      cyc(1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
